// File: rtl/depacketizer_pkg.sv
// Types and constants shared by the depacketizer and its output register.
package depacketizer_pkg;
    `include "params.svh"

    localparam int unsigned DW         = `DW;
    localparam int unsigned PKT_LEN    = `PKT_LEN;
    localparam int unsigned CNT_W      = `PKT_LEN_LOG;
    localparam int unsigned SID_W      = 10;
    localparam int unsigned PAYLOAD_W  = 1 + SID_W + DW;

    // Index of the last BODY flit within a packet (HEAD and TAIL excluded).
    localparam logic [CNT_W-1:0] LAST_BODY_IDX = CNT_W'(PKT_LEN - 3);

    localparam logic [1:0] TYPE_HEAD = `HEAD;
    localparam logic [1:0] TYPE_BODY = `BODY;
    localparam logic [1:0] TYPE_TAIL = `TAIL;

    localparam logic [1:0] ERR_NOHEAD = 2'b01;
    localparam logic [1:0] ERR_SHORT  = 2'b10;
    localparam logic [1:0] ERR_LONG   = 2'b11;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBody  = 2'd1,
        StTailw = 2'd2,
        StDrop  = 2'd3
    } state_e;
endpackage

// File: rtl/params.svh
// Shared flit-format macros for the HEAD/BODY/TAIL packet protocol.
`ifndef PARAMS_SVH
`define PARAMS_SVH
`define DW          32
`define PKT_LEN     6
`define PKT_LEN_LOG 3
`define HEAD        2'b00
`define BODY        2'b01
`define TAIL        2'b10
`endif

// File: rtl/pe_out_reg.sv
// Single-entry valid/ready pipeline register; loads and drains in the same cycle.
module pe_out_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    output logic [W-1:0] out_data_o,
    input  logic         out_ready_i
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign in_ready_o  = ~valid_q | out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: rtl/depacketizer.sv
// Receives HEAD/BODY/TAIL packets from the router, checks framing and forwards BODY payloads.
module depacketizer
    import depacketizer_pkg::*;
#(
    parameter bit               CHECK_SID = 1'b0,
    parameter logic [SID_W-1:0] EXP_SID   = 10'd0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             valid_i_nw,
    input  logic [DW-1:0]    data_i_nw,
    output logic             ready_o_nw,
    output logic             valid_o_pe,
    output logic [DW-1:0]    data_o_pe,
    output logic             last_o_pe,
    output logic [SID_W-1:0] sid_o_pe,
    input  logic             ready_i_pe,
    output logic             err_o,
    output logic [1:0]       err_code_o,
    output logic [15:0]      pkt_cnt_o
);
    state_e           state_q, state_d;
    logic [SID_W-1:0] sid_q, sid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             orphan_q, orphan_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [15:0]      pkt_q, pkt_d;

    logic             accept, is_head, is_tail, sid_ok, start_head;
    logic             load, load_last, reg_in_ready;
    logic [DW-1:0]    body_data;
    logic [PAYLOAD_W-1:0] reg_out;

    assign is_head   = data_i_nw[DW-1:DW-2] == TYPE_HEAD;
    assign is_tail   = data_i_nw[DW-1:DW-2] == TYPE_TAIL;
    assign sid_ok    = !CHECK_SID || (data_i_nw[SID_W-1:0] == EXP_SID);
    assign body_data = {2'b00, data_i_nw[DW-3:0]};

    assign ready_o_nw = (state_q == StBody) ? reg_in_ready : 1'b1;
    assign accept     = valid_i_nw & ready_o_nw;

    always_comb begin
        state_d    = state_q;
        sid_d      = sid_q;
        cnt_d      = cnt_q;
        orphan_d   = orphan_q;
        err_d      = 1'b0;
        code_d     = code_q;
        pkt_d      = pkt_q;
        load       = 1'b0;
        load_last  = 1'b0;
        start_head = 1'b0;
        if (accept) begin
            unique case (state_q)
                StIdle: begin
                    if (is_head) begin
                        start_head = 1'b1;
                    end else begin
                        // Only the first flit of a headless fragment is reported.
                        if (!orphan_q) begin
                            err_d  = 1'b1;
                            code_d = ERR_NOHEAD;
                        end
                        orphan_d = ~is_tail;
                    end
                end
                StBody: begin
                    if (is_head) begin
                        err_d      = 1'b1;
                        code_d     = ERR_SHORT;
                        start_head = 1'b1;
                    end else if (is_tail) begin
                        err_d   = 1'b1;
                        code_d  = ERR_SHORT;
                        state_d = StIdle;
                    end else begin
                        load      = 1'b1;
                        load_last = (cnt_q == LAST_BODY_IDX);
                        cnt_d     = cnt_q + 1'b1;
                        if (load_last) state_d = StTailw;
                    end
                end
                StTailw: begin
                    if (is_head) begin
                        err_d      = 1'b1;
                        code_d     = ERR_LONG;
                        start_head = 1'b1;
                    end else if (is_tail) begin
                        pkt_d   = pkt_q + 16'd1;
                        state_d = StIdle;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_LONG;
                        state_d = StDrop;
                    end
                end
                StDrop: begin
                    if (is_tail) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
            if (start_head) begin
                orphan_d = 1'b0;
                if (sid_ok) begin
                    sid_d   = data_i_nw[SID_W-1:0];
                    cnt_d   = '0;
                    state_d = StBody;
                end else begin
                    state_d = StDrop;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            sid_q    <= '0;
            cnt_q    <= '0;
            orphan_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
            pkt_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            sid_q    <= sid_d;
            cnt_q    <= cnt_d;
            orphan_q <= orphan_d;
            err_q    <= err_d;
            code_q   <= code_d;
            pkt_q    <= pkt_d;
        end
    end

    assign err_o      = err_q;
    assign err_code_o = code_q;
    assign pkt_cnt_o  = pkt_q;

    pe_out_reg #(
        .W(PAYLOAD_W)
    ) u_out_reg (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid_i (load),
        .in_ready_o (reg_in_ready),
        .in_data_i  ({load_last, data_i_nw[SID_W-1:0] & '0 | sid_q, body_data}),
        .out_valid_o(valid_o_pe),
        .out_data_o (reg_out),
        .out_ready_i(ready_i_pe)
    );

    assign last_o_pe = reg_out[PAYLOAD_W-1];
    assign sid_o_pe  = reg_out[DW +: SID_W];
    assign data_o_pe = reg_out[DW-1:0];
endmodule

// File: doc/depacketizer.md
Name: depacketizer

Overview:
Network-side receiver for the HEAD/BODY/TAIL flit protocol emitted by the PE-side packer.
- Parses each packet arriving from the router local port.
- Latches the 10-bit source id carried in HEAD.
- Strips HEAD and TAIL, delivers BODY payloads to the PE with a last marker.
- Enforces the fixed length of `PKT_LEN flits and reports framing errors.
- Sits between the router ejection port and the PE input, replacing pass-through filtering where framing must be checked.

Parameters:
CHECK_SID, 0, 1: packets whose HEAD sid != EXP_SID are silently discarded up to and including TAIL.
EXP_SID, 10'd0, expected source id when CHECK_SID=1.

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
valid_i_nw  input  1  flit valid from network
data_i_nw  input  `DW  flit; type in [`DW-1:`DW-2]; sid in [9:0] for HEAD
ready_o_nw  output  1  flit accepted when valid_i_nw & ready_o_nw
valid_o_pe  output  1  payload valid to PE
data_o_pe  output  `DW  {2'b00, body[`DW-3:0]}
last_o_pe  output  1  set on body flit number `PKT_LEN-2 of a packet
sid_o_pe  output  10  sid of the packet owning the current payload
ready_i_pe  input  1  PE ready
err_o  output  1  one-cycle error pulse
err_code_o  output  2  01 NOHEAD, 10 SHORT, 11 LONG; held until next error
pkt_cnt_o  output  16  count of correctly framed delivered packets, wraps at 2^16

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; body_cnt 0; output register empty.
- FSM states: IDLE, BODY, TAILW, DROP. Every transition below occurs only on an accepted flit.
- IDLE: ready_o_nw=1.
  - HEAD with sid accepted (CHECK_SID=0 or sid==EXP_SID) -> latch sid, body_cnt=0, go BODY.
  - HEAD with mismatching sid -> DROP, no error.
  - BODY or TAIL -> discard, err NOHEAD, stay IDLE.
- BODY: ready_o_nw = ~valid_o_pe | ready_i_pe.
  - BODY flit -> load output register: data, sid, last=(body_cnt==`PKT_LEN-3); body_cnt++.
  - After the BODY flit with body_cnt==`PKT_LEN-3 -> TAILW.
  - TAIL -> err SHORT, go IDLE. No last is ever emitted for that packet.
  - HEAD -> err SHORT, latch new sid, body_cnt=0, stay BODY. The sid filter applies to the new HEAD.
- TAILW: ready_o_nw=1.
  - TAIL -> pkt_cnt_o++, go IDLE.
  - BODY -> discard, err LONG, go DROP.
  - HEAD -> err LONG, treat as a new HEAD (IDLE rules).
- DROP: ready_o_nw=1. Discard all flits; TAIL -> IDLE. A HEAD in DROP is discarded without error.
- Any other type code (not `HEAD/`BODY/`TAIL) is treated as BODY.
- Output register:
  - Single entry, 1-cycle latency from accepted BODY flit to valid_o_pe.
  - Full throughput: load and drain in the same cycle when ready_i_pe=1.
  - data_o_pe, last_o_pe and sid_o_pe stay stable while valid_o_pe & ~ready_i_pe.
- A HEAD/TAIL may be consumed while the output register holds an undrained payload; the payload is unaffected.
- err_o pulses the cycle after the offending flit is accepted; err_code_o updates in the same cycle.
- pkt_cnt_o increments the cycle after TAIL acceptance; FFFF -> 0000.
- Reset mid-packet: returns to IDLE and clears the output register immediately (asynchronous). The remainder of the interrupted packet then produces NOHEAD errors on its first flit.

Decomposition:
- params.svh supplies `DW, `PKT_LEN, `PKT_LEN_LOG, `HEAD, `BODY, `TAIL.
- Add to the shared package:
  - state encodings (IDLE/BODY/TAILW/DROP)
  - error code constants (ERR_NOHEAD=2'b01, ERR_SHORT=2'b10, ERR_LONG=2'b11)
  - SID_W=10
- One sub-module: pe_out_reg, a single-entry valid/ready pipeline register carrying {last, sid, data}.

Test Plan:
- `PKT_LEN=6, HEAD sid=10'h155, BODY 1..4, TAIL, ready_i_pe=1 -> 4 payloads, last on 4th, sid_o_pe=10'h155, pkt_cnt_o=1, err_o never set.
- Same packet with ready_i_pe toggling 1,0,0,1,... -> no payload lost/duplicated, outputs stable while stalled, ready_o_nw low only when register full and PE not ready.
- HEAD, BODY x2, TAIL -> 2 payloads with no last, err SHORT (10), pkt_cnt_o unchanged; following good packet delivered normally.
- HEAD, BODY x5, TAIL -> 4 payloads, err LONG (11) on 5th body, 5th discarded, DROP until TAIL, pkt_cnt_o unchanged.
- BODY with no HEAD -> err NOHEAD (01), nothing to PE. CHECK_SID=1, EXP_SID=3, packet with sid=4 -> fully dropped, no error, pkt_cnt_o unchanged.
- rstn asserted after 2 body flits -> valid_o_pe=0 and pkt_cnt_o=0 immediately. After release, the leftover BODY x2 and TAIL produce a single NOHEAD error; the next packet delivers cleanly.
